// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared constants and types for the instruction-fetch stage.
//   - NOP_INST       : encoding used for a bubble in IF/ID
//   - OPC_HI/OPC_LO  : opcode bit range within a 16-bit instruction
//   - fetch_state_e  : fetch FSM encoding (FS_BOOT / FS_RUN)
package fetch_stage_pkg;

    localparam logic [15:0] NOP_INST = 16'h0000;
    localparam int          OPC_HI   = 15;
    localparam int          OPC_LO   = 12;

    typedef enum logic {
        FS_BOOT = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_e;

    // Opcode field of an instruction word; a bubble decodes as opcode 0.
    function automatic logic [3:0] opcode_of(input logic [15:0] inst);
        return inst[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// ifid_reg
//   IF/ID pipeline register holding valid / instruction / PC+1.
//   Ports:
//     clk, rst_n        : clock, synchronous active-low reset
//     load              : capture next_inst / next_pc1 and mark valid
//     hold              : keep current contents
//     bubble            : clear to an invalid NOP with pc1 = 0
//     next_inst/next_pc1: data captured on load
//     valid, inst, pc1  : register contents
//   Control priority: reset > bubble > hold > load. With no control
//   asserted the register simply keeps its value.
module ifid_reg #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              hold,
    input  logic              bubble,
    input  logic [INST_W-1:0] next_inst,
    input  logic [PC_W-1:0]   next_pc1,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc1
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= '0;
            pc1   <= '0;
        end else if (bubble) begin
            valid <= 1'b0;
            inst  <= '0;
            pc1   <= '0;
        end else if (hold) begin
            valid <= valid;
            inst  <= inst;
            pc1   <= pc1;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= next_inst;
            pc1   <= next_pc1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: PC register, BOOT/RUN control FSM, redirect
//   bubble counter and the IF/ID register.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     imem_addr    : instruction memory address (the pc register itself)
//     imem_data    : combinational instruction memory read data
//     stall        : load-use hazard, freeze pc and IF/ID
//     redirect     : taken branch / j / jr / jal resolved this cycle
//     redirect_pc  : redirect target
//     ifid_valid   : IF/ID holds a real instruction (0 = bubble)
//     ifid_inst    : instruction to decode (0 for a bubble)
//     ifid_pc1     : PC+1 of that instruction
//     flush_cnt    : redirect bubbles inserted, saturating at 255
//     state        : current fetch FSM state (observation only)
//   Control semantics: in RUN, redirect beats stall, stall beats normal
//   advance. BOOT ignores both and always inserts one bubble.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              ifid_valid,
    output logic [INST_W-1:0] ifid_inst,
    output logic [PC_W-1:0]   ifid_pc1,
    output logic [7:0]        flush_cnt,
    output fetch_state_e      state
);

    fetch_state_e    st, st_next;
    logic [PC_W-1:0] pc, pc_next, pc_plus1;
    logic [7:0]      cnt, cnt_next;
    logic            ld, hld, bub;

    // Modulo-2^PC_W increment; wraps naturally at all-ones.
    assign pc_plus1 = pc + {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= FS_BOOT;
            pc  <= '0;
            cnt <= '0;
        end else begin
            st  <= st_next;
            pc  <= pc_next;
            cnt <= cnt_next;
        end
    end

    always_comb begin
        st_next  = st;
        pc_next  = pc;
        cnt_next = cnt;
        ld       = 1'b0;
        hld      = 1'b0;
        bub      = 1'b0;
        case (st)
            FS_BOOT: begin
                // One settled cycle for instruction memory before fetching.
                st_next = FS_RUN;
                bub     = 1'b1;
            end
            FS_RUN: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                    bub     = 1'b1;
                    if (cnt != 8'hFF) cnt_next = cnt + 8'd1;
                end else if (stall) begin
                    hld = 1'b1;
                end else begin
                    ld      = 1'b1;
                    pc_next = pc_plus1;
                end
            end
            default: begin
                st_next = FS_BOOT;
                bub     = 1'b1;
            end
        endcase
    end

    ifid_reg #(
        .PC_W  (PC_W),
        .INST_W(INST_W)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .hold     (hld),
        .bubble   (bub),
        .next_inst(imem_data),
        .next_pc1 (pc_plus1),
        .valid    (ifid_valid),
        .inst     (ifid_inst),
        .pc1      (ifid_pc1)
    );

    assign imem_addr = pc;
    assign flush_cnt = cnt;
    assign state     = st;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. Instruction memory returns
//   16'h1000 + address. Outputs are sampled 1 time unit after each
//   rising edge; expected values are hand-computed constants.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [7:0]   imem_addr;
    logic [15:0]  imem_data;
    logic         stall;
    logic         redirect;
    logic [7:0]   redirect_pc;
    logic         ifid_valid;
    logic [15:0]  ifid_inst;
    logic [7:0]   ifid_pc1;
    logic [7:0]   flush_cnt;
    fetch_state_e state;

    int vectors = 0;
    int errors  = 0;

    fetch_stage #(.PC_W(8), .INST_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ifid_valid (ifid_valid),
        .ifid_inst  (ifid_inst),
        .ifid_pc1   (ifid_pc1),
        .flush_cnt  (flush_cnt),
        .state      (state)
    );

    // Clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = 16'h1000 + {8'h00, imem_addr};

    // Driver / checker tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic e_valid,
                           input logic [15:0] e_inst, input logic [7:0] e_pc1);
        chk({tag, ".pc"},    32'(imem_addr),  32'(e_pc));
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(e_valid));
        chk({tag, ".inst"},  32'(ifid_inst),  32'(e_inst));
        chk({tag, ".pc1"},   32'(ifid_pc1),   32'(e_pc1));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        step(); step();
        chk_all("reset", 8'h00, 1'b0, 16'h0000, 8'h00);
        chk("reset.flush", 32'(flush_cnt), 32'd0);
        chk("reset.state", 32'(state), 32'(FS_BOOT));

        // Free run
        rst_n = 1'b1;
        step();
        chk_all("edge1", 8'h00, 1'b0, 16'h0000, 8'h00);
        chk("edge1.state", 32'(state), 32'(FS_RUN));
        step();
        chk_all("edge2", 8'h01, 1'b1, 16'h1000, 8'h01);
        step();
        chk_all("edge3", 8'h02, 1'b1, 16'h1001, 8'h02);
        step();
        chk_all("edge4", 8'h03, 1'b1, 16'h1002, 8'h03);

        // Stall for three cycles
        stall = 1'b1;
        step(); chk_all("stall1", 8'h03, 1'b1, 16'h1002, 8'h03);
        step(); chk_all("stall2", 8'h03, 1'b1, 16'h1002, 8'h03);
        step(); chk_all("stall3", 8'h03, 1'b1, 16'h1002, 8'h03);
        stall = 1'b0;
        step(); chk_all("unstall", 8'h04, 1'b1, 16'h1003, 8'h04);
        step(); chk_all("run5", 8'h05, 1'b1, 16'h1004, 8'h05);

        // Redirect at pc=5 to 0x40
        redirect = 1'b1; redirect_pc = 8'h40;
        step();
        chk_all("redir", 8'h40, 1'b0, 16'h0000, 8'h00);
        chk("redir.flush", 32'(flush_cnt), 32'd1);
        redirect = 1'b0;
        step();
        chk_all("redir_tgt", 8'h41, 1'b1, 16'h1040, 8'h41);

        // Stall and redirect together: redirect wins
        stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h10;
        step();
        chk_all("stall_redir", 8'h10, 1'b0, 16'h0000, 8'h00);
        chk("stall_redir.flush", 32'(flush_cnt), 32'd2);
        stall = 1'b0; redirect = 1'b0;
        step();
        chk_all("stall_redir_tgt", 8'h11, 1'b1, 16'h1010, 8'h11);

        // PC wrap
        redirect = 1'b1; redirect_pc = 8'hFF;
        step();
        chk_all("wrap_redir", 8'hFF, 1'b0, 16'h0000, 8'h00);
        chk("wrap_redir.flush", 32'(flush_cnt), 32'd3);
        redirect = 1'b0;
        step();
        chk_all("wrap1", 8'h00, 1'b1, 16'h10FF, 8'h00);
        step();
        chk_all("wrap2", 8'h01, 1'b1, 16'h1000, 8'h01);

        // Reset mid-run with stall and redirect high
        rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h33;
        step();
        chk_all("midreset", 8'h00, 1'b0, 16'h0000, 8'h00);
        chk("midreset.flush", 32'(flush_cnt), 32'd0);
        chk("midreset.state", 32'(state), 32'(FS_BOOT));

        // BOOT ignores stall and redirect
        rst_n = 1'b1;
        step();
        chk_all("boot_ignore", 8'h00, 1'b0, 16'h0000, 8'h00);
        chk("boot_ignore.flush", 32'(flush_cnt), 32'd0);
        chk("boot_ignore.state", 32'(state), 32'(FS_RUN));

        // flush_cnt saturation over 256 redirects
        stall = 1'b0; redirect = 1'b1; redirect_pc = 8'h20;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 1)   chk("sat.1",   32'(flush_cnt), 32'd1);
            if (i == 254) chk("sat.254", 32'(flush_cnt), 32'd254);
            if (i == 255) chk("sat.255", 32'(flush_cnt), 32'd255);
            if (i == 256) chk("sat.256", 32'(flush_cnt), 32'd255);
        end
        chk_all("sat_end", 8'h20, 1'b0, 16'h0000, 8'h00);
        redirect = 1'b0;
        step();
        chk_all("sat_resume", 8'h21, 1'b1, 16'h1020, 8'h21);
        chk("sat_resume.flush", 32'(flush_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
